// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream plus control/status handshake for the config-chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] readback_data;
  logic              readback_valid;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output start, abort, word_data, word_valid,
    input  word_ready, readback_data, readback_valid, busy, done, aborted
  );

  modport slave (
    input  start, abort, word_data, word_valid,
    output word_ready, readback_data, readback_valid, busy, done, aborted
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Shifts bitstream words serially into a config-chain and returns the displaced
// tail bits as readback words.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 30
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  ccff_chain_loader_if.slave   bus,
  output logic                 ccff_head,
  output logic                 shift_en,
  input  logic                 ccff_tail
);
  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int CW   = $clog2(WORD_W + 1);
  localparam int KW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [BL_W-1:0]   bits_left;
  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k;
  logic [WORD_W-1:0] shreg, shreg_nx;
  logic [WORD_W-1:0] rb_acc, rb_nx, rbd_q;
  logic [CW-1:0]     n_calc;
  logic              ready_q, shift_en_q, head_q, busy_q, done_q, aborted_q, rbv_q;

  always_comb begin
    shreg_nx = shreg >> 1;
    rb_nx    = rb_acc | (WORD_W'(ccff_tail) << k);
    n_calc   = (32'(bits_left) >= WORD_W) ? CW'(WORD_W) : CW'(bits_left);
  end

  // abort cancels the shift of the current cycle too, so the chain never
  // advances on the cycle the load is cancelled
  assign bus.word_ready     = ready_q & ~bus.abort;
  assign shift_en           = shift_en_q & ~bus.abort;
  assign ccff_head          = head_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.aborted        = aborted_q;
  assign bus.readback_valid = rbv_q;
  assign bus.readback_data  = rbd_q;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state      <= IDLE;
      bits_left  <= '0;
      cnt        <= '0;
      k          <= '0;
      shreg      <= '0;
      rb_acc     <= '0;
      rbd_q      <= '0;
      ready_q    <= 1'b0;
      shift_en_q <= 1'b0;
      head_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      rbv_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rbv_q     <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state      <= IDLE;
        ready_q    <= 1'b0;
        shift_en_q <= 1'b0;
        head_q     <= 1'b0;
        busy_q     <= 1'b0;
        aborted_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            state     <= LOAD;
            bits_left <= BL_W'(CHAIN_LEN);
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
          LOAD: if (bus.word_valid) begin
            state      <= SHIFT;
            ready_q    <= 1'b0;
            shreg      <= bus.word_data;
            rb_acc     <= '0;
            k          <= '0;
            cnt        <= n_calc;
            shift_en_q <= 1'b1;
            head_q     <= bus.word_data[0];
          end
          SHIFT: begin
            shreg     <= shreg_nx;
            rb_acc    <= rb_nx;
            k         <= k + KW'(1);
            bits_left <= bits_left - BL_W'(1);
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              shift_en_q <= 1'b0;
              head_q     <= 1'b0;
              rbd_q      <= rb_nx;
              rbv_q      <= 1'b1;
              if (bits_left == BL_W'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state   <= LOAD;
                ready_q <= 1'b1;
              end
            end else begin
              head_q <= shreg_nx[0];
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: default 30-bit chain loader plus an 8-bit single-word instance,
// each driving a behavioural shift-register chain.
module tb_ccff_chain_loader;
  localparam int W = 8;
  localparam int L = 30;

  logic prog_clk   = 1'b0;
  logic prog_reset = 1'b1;
  logic fill_ones  = 1'b0;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(W)) bus ();
  ccff_chain_loader_if #(.WORD_W(W)) bus8 ();

  logic ccff_head, shift_en, ccff_tail;
  logic head8, en8, tail8;
  logic [L-1:0] chain;
  logic [7:0]   chain8;

  assign ccff_tail = chain[0];
  assign tail8     = chain8[0];

  always @(posedge prog_clk) begin
    if (fill_ones) begin
      chain  <= '1;
      chain8 <= '1;
    end else begin
      if (shift_en) chain  <= {ccff_head, chain[L-1:1]};
      if (en8)      chain8 <= {head8, chain8[7:1]};
    end
  end

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(bus),
    .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail)
  );

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(8)) dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(bus8),
    .ccff_head(head8), .shift_en(en8), .ccff_tail(tail8)
  );

  int checks = 0;
  int errors = 0;
  int done_t, abort_t, nsh, nrb, stall_bad, stall_seen;
  logic busy_at_end;
  logic [W-1:0] rb [8];
  logic [W-1:0] words [4];

  task automatic fill_chain();
    @(posedge prog_clk); #1 fill_ones = 1'b1;
    @(posedge prog_clk); #1 fill_ones = 1'b0;
  endtask

  // Drives one load on the 30-bit instance; cycle 0 is the start cycle.
  task automatic run_load(input int stall, input int abort_off, input int restart_off,
                          input int reset_off);
    int t, widx, stall_left;
    logic acc, stalling;
    logic [L-1:0] snap;
    t = 0; widx = 0; stall_left = stall; stalling = 1'b0; snap = '0;
    done_t = -1; abort_t = -1; nsh = 0; nrb = 0; stall_bad = 0; stall_seen = 0;
    @(posedge prog_clk); #1;
    bus.start = 1'b1; bus.word_valid = 1'b1; bus.word_data = words[0];
    forever begin
      @(negedge prog_clk);
      acc = bus.word_ready && bus.word_valid;
      if (shift_en) nsh++;
      if (bus.readback_valid && nrb < 8) begin rb[nrb] = bus.readback_data; nrb++; end
      if (bus.done) done_t = t;
      if (bus.aborted) abort_t = t;
      if (stalling) begin
        stall_seen++;
        if (!bus.word_ready || shift_en || chain !== snap) stall_bad++;
      end
      busy_at_end = bus.busy;
      if (done_t >= 0 || abort_t >= 0 || t == reset_off || t >= 150) break;
      @(posedge prog_clk); #1;
      t++;
      if (acc) widx++;
      bus.start     = (t == restart_off);
      bus.abort     = (t == abort_off);
      prog_reset    = (t == reset_off);
      bus.word_data = words[widx % 4];
      stalling = (widx == 1 && stall_left > 0 && bus.word_ready);
      if (stalling) begin
        if (stall_left == stall) snap = chain;
        stall_left--;
      end
      bus.word_valid = !stalling;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.word_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+6:0] outs;
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b0;
    @(negedge prog_clk);
    outs = {bus.word_ready, shift_en, ccff_head, bus.busy, bus.done, bus.aborted,
            bus.readback_valid, bus.readback_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    outs = {bus8.word_ready, en8, head8, bus8.busy, bus8.done, bus8.aborted,
            bus8.readback_valid, bus8.readback_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs8 got %h want 0", outs); end
  endtask

  task automatic test_basic();
    fill_chain();
    run_load(0, -1, -1, -1);
    checks++; if (done_t !== 35) begin errors++; $display("FAIL basic_done_cycle got %0d want 35", done_t); end
    checks++; if (nsh !== 30) begin errors++; $display("FAIL basic_shift_count got %0d want 30", nsh); end
    checks++; if (nrb !== 4) begin errors++; $display("FAIL basic_rb_count got %0d want 4", nrb); end
    checks++;
    if ({rb[0], rb[1], rb[2], rb[3]} !== 32'hFFFFFF3F) begin
      errors++; $display("FAIL basic_readback got %h %h %h %h want ff ff ff 3f", rb[0], rb[1], rb[2], rb[3]);
    end
    @(negedge prog_clk);
    checks++;
    if (chain !== {6'h15, 8'hFF, 8'h3C, 8'hA5}) begin
      errors++; $display("FAIL basic_chain got %h want %h", chain, {6'h15, 8'hFF, 8'h3C, 8'hA5});
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_rerun();
    run_load(0, -1, -1, -1);
    checks++; if (done_t !== 35) begin errors++; $display("FAIL rerun_done_cycle got %0d want 35", done_t); end
    checks++;
    if (nrb !== 4 || {rb[0], rb[1], rb[2], rb[3]} !== 32'hA53CFF15) begin
      errors++; $display("FAIL rerun_readback got %0d words %h %h %h %h want a5 3c ff 15", nrb, rb[0], rb[1], rb[2], rb[3]);
    end
  endtask

  task automatic test_stall();
    fill_chain();
    run_load(5, -1, -1, -1);
    checks++; if (done_t !== 40) begin errors++; $display("FAIL stall_done_cycle got %0d want 40", done_t); end
    checks++; if (stall_seen !== 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", stall_seen); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad); end
    checks++; if (nsh !== 30) begin errors++; $display("FAIL stall_shift_count got %0d want 30", nsh); end
  endtask

  task automatic test_start_busy();
    run_load(0, -1, 5, -1);
    checks++; if (done_t !== 35) begin errors++; $display("FAIL start_busy_done got %0d want 35", done_t); end
    @(negedge prog_clk); @(negedge prog_clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_busy_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_abort();
    fill_chain();
    run_load(0, 13, -1, -1);
    checks++; if (abort_t !== 14) begin errors++; $display("FAIL abort_pulse_cycle got %0d want 14", abort_t); end
    checks++; if (done_t !== -1) begin errors++; $display("FAIL abort_no_done got %0d want -1", done_t); end
    checks++; if (busy_at_end !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_at_end); end
    checks++; if (nsh !== 10) begin errors++; $display("FAIL abort_shift_count got %0d want 10", nsh); end
    checks++; if (nrb !== 1) begin errors++; $display("FAIL abort_rb_count got %0d want 1", nrb); end
    checks++;
    if (chain !== {2'b00, 8'hA5, 20'hFFFFF}) begin
      errors++; $display("FAIL abort_chain got %h want %h", chain, {2'b00, 8'hA5, 20'hFFFFF});
    end
    run_load(0, -1, -1, -1);
    checks++;
    if (done_t !== 35 || nsh !== 30) begin
      errors++; $display("FAIL abort_restart got done %0d shifts %0d want 35 30", done_t, nsh);
    end
  endtask

  task automatic test_reset_mid();
    logic [W+6:0] outs;
    int n_ab;
    run_load(0, -1, -1, 5);
    @(posedge prog_clk); #1 prog_reset = 1'b0;
    @(negedge prog_clk);
    outs = {bus.word_ready, shift_en, ccff_head, bus.busy, bus.done, bus.aborted,
            bus.readback_valid, bus.readback_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs got %h want 0", outs); end
    n_ab = 0;
    repeat (3) begin @(negedge prog_clk); if (bus.aborted) n_ab++; end
    checks++; if (n_ab !== 0) begin errors++; $display("FAIL reset_mid_aborted got %0d pulses want 0", n_ab); end
  endtask

  task automatic test_small();
    int t, n8, nr8;
    logic [7:0] r8;
    fill_chain();
    t = 0; done_t = -1; n8 = 0; nr8 = 0; r8 = '0;
    @(posedge prog_clk); #1;
    bus8.start = 1'b1; bus8.word_valid = 1'b1; bus8.word_data = 8'h5A;
    forever begin
      @(negedge prog_clk);
      if (en8) n8++;
      if (bus8.readback_valid) begin r8 = bus8.readback_data; nr8++; end
      if (bus8.done) done_t = t;
      if (done_t >= 0 || t >= 60) break;
      @(posedge prog_clk); #1;
      t++;
      bus8.start = 1'b0;
    end
    bus8.word_valid = 1'b0;
    @(negedge prog_clk);
    checks++; if (done_t !== 10) begin errors++; $display("FAIL small_done_cycle got %0d want 10", done_t); end
    checks++; if (n8 !== 8) begin errors++; $display("FAIL small_shift_count got %0d want 8", n8); end
    checks++;
    if (nr8 !== 1 || r8 !== 8'hFF) begin errors++; $display("FAIL small_readback got %0d x %h want 1 x ff", nr8, r8); end
    checks++; if (chain8 !== 8'h5A) begin errors++; $display("FAIL small_chain got %h want 5a", chain8); end
  endtask

  initial begin
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h15};
    bus.start = 1'b0; bus.abort = 1'b0; bus.word_valid = 1'b0; bus.word_data = '0;
    bus8.start = 1'b0; bus8.abort = 1'b0; bus8.word_valid = 1'b0; bus8.word_data = '0;
    test_reset();
    test_basic();
    test_rerun();
    test_stall();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
